mem_bus_arbiter: RTL
====================

# mem_bus_arbiter

Two-master arbiter that shares the single FemtoRV32-style memory/peripheral bus (RAM, UART, mult, dpRAM chip-select decoder) between the CPU (master 0) and a second requester such as a DMA or debug port (master 1). Each master sees the native strobe/mask/busy handshake. The arbiter captures requests, serialises them onto the shared bus with round-robin or fixed priority, and returns read data after a fixed slave latency.

## Interface
- `RD_LAT`, default 1: slave read latency in cycles from the `s_rstrb` cycle to valid `s_rdata`; legal values are 1..4.
- `FAIR`, default 1: 1 selects round-robin arbitration; 0 gives master 0 fixed priority.

Ports:
- `clk`  in  1  system clock
- `resetn`  in  1  reset; synchronous, active-low
- `m0_addr` / `m1_addr`  in  32  request address
- `m0_wdata` / `m1_wdata`  in  32  write data
- `m0_wmask` / `m1_wmask`  in  4  byte write mask; nonzero means write request
- `m0_rstrb` / `m1_rstrb`  in  1  one-cycle read strobe
- `m0_rdata` / `m1_rdata`  out  32  registered read data for that master
- `m0_rbusy` / `m1_rbusy`  out  1  read outstanding
- `m0_wbusy` / `m1_wbusy`  out  1  write outstanding
- `s_addr`  out  32  shared-bus address, fed to the decoder
- `s_wdata`  out  32  shared-bus write data
- `s_wmask`  out  4  shared-bus write mask
- `s_rstrb`  out  1  shared-bus read strobe
- `s_rdata`  in  32  shared-bus read data, from the decoder mux

## Operation
- **Request:** a cycle with `mX_rstrb`=1 or `mX_wmask`≠0 while master X has nothing outstanding.
  - If both are set in the same cycle, it is treated as a write and `rstrb` is ignored.
  - Requests from a master that already has one outstanding are dropped; that is a protocol violation.
- **Per-master pend register** holds {addr, wdata, wmask, is_rd, valid}.
- **Arbitration candidate** for master X: the pend entry if valid, otherwise the new request this cycle.
- **FSM states:** IDLE, ISSUE, RDWAIT.
  - **IDLE:** if any candidate exists, load the winner into the issue register and go to ISSUE. A losing candidate that arrived as a new request is written into its pend register.
  - **ISSUE:** drive `s_*` from the issue register for exactly one cycle. `s_rstrb`=is_rd; `s_wmask`=mask for writes, else 0. A write then goes to IDLE and clears its owner's outstanding flag. A read goes to RDWAIT with the counter loaded to `RD_LAT`.
  - **RDWAIT:** decrement the counter each cycle. On the cycle the counter reaches 1, capture `s_rdata` into the owner's `mX_rdata`, clear the outstanding flag, and go to IDLE.
  - New requests arriving during ISSUE or RDWAIT go to pend.
- **Arbitration:**
  - `FAIR`=1: on contention, grant the master other than `last_owner`.
  - `FAIR`=0: master 0 always wins.
  - `last_owner` updates on every grant.
- **`s_rstrb` and `s_wmask`** are 0 outside ISSUE. `s_addr` and `s_wdata` hold their last values.
- **Busy flags:**
  - `mX_rbusy`=1 from the cycle after a read request until the cycle after capture.
  - `mX_wbusy`=1 from the cycle after a write request through its ISSUE cycle.
- **`mX_rdata`** holds its value until that master's next read completes.
- **Reset** (`resetn`=0 at a clock edge):
  - FSM goes to IDLE and all pend/outstanding flags clear.
  - `s_rstrb`=0, `s_wmask`=0, `s_addr`=0, `s_wdata`=0.
  - All busy outputs are 0 and both `mX_rdata` are 0.
  - `last_owner`=1, so master 0 wins the first tie.
  - Requests presented during reset are dropped. An in-flight read is abandoned and its data is never returned.

## Timing
Times are for an uncontended request at cycle T.
- **Write:** ISSUE at T+1, with `wbusy` high. `wbusy` is low and the FSM is in IDLE at T+2.
- **Read:** ISSUE at T+1; `s_rdata` is valid at T+1+`RD_LAT`. `mX_rdata` updates and `rbusy` falls at T+2+`RD_LAT`; `rbusy` is high from T+1 through T+1+`RD_LAT`. With `RD_LAT`=1 this is 3 cycles from strobe to data.
- **Bus occupancy:** a write holds the bus 1 cycle plus 1 IDLE cycle; a read holds it 1+`RD_LAT` cycles plus 1 IDLE cycle.
- **Waiting master:** its request is issued on the IDLE cycle following the winner's completion, 1 cycle after that.
- **Fairness:** with `FAIR`=1, a pending request waits at most one other transaction.
- **All outputs are registered.** There is no combinational path from `m*` or `s_rdata` to any output.

## Structure
- **Shared package `mem_bus_arb_pkg`:**
  - state encoding: `ST_IDLE`=2'd0, `ST_ISSUE`=2'd1, `ST_RDWAIT`=2'd2
  - `RD_LAT` counter width (3 bits)
  - master IDs `M_CPU`=0, `M_AUX`=1
- **Sub-module `mem_bus_arb_port`:** instantiated twice. Each holds request detection, the pend register, the outstanding flag, busy generation, and the `rdata` register. The top level holds the FSM, the issue register, `last_owner` and the latency counter.

## Test plan
- **m0 write, idle bus:** m0 writes addr 0x00400000, wdata 0x41, wmask 0xF at T.
  - `s_wmask`=0xF and `s_addr`=0x00400000 at T+1 only.
  - `m0_wbusy` is high at T+1 and low at T+2.
- **m1 read, `RD_LAT`=2:** m1 reads 0x00450010 at T; the slave returns 0xDEADBEEF at T+3.
  - `m1_rdata`=0xDEADBEEF at T+4.
  - `m1_rbusy` is high T+1..T+3.
  - `m0_rdata` is unchanged.
- **Simultaneous reads, `FAIR`=1, after reset:**
  - m0 is issued at T+1 and m1 at T+4 (`RD_LAT`=1).
  - A repeat of the same collision grants m1 first.
- **Contention, `FAIR`=0:** m0 issues back-to-back reads while m1 keeps one read pending. m1 is served only on an IDLE cycle where m0 has no candidate, and m0 always wins ties.
- **Reset during RDWAIT:** assert `resetn`=0 for one cycle while the FSM is in RDWAIT.
  - Next cycle: IDLE, all busy outputs 0, both `rdata` 0, `s_rstrb`=0.
  - The following m0 request completes normally.
- **Violation and precedence:**
  - A second strobe from m0 while `m0_rbusy`=1 produces no extra `s_rstrb`.
  - `rstrb` together with wmask 0x3 issues a single write with `s_rstrb`=0.

Source files
------------

// File: rtl/mem_bus_arb_pkg.sv
// Shared types and constants for the two-master memory bus arbiter.
package mem_bus_arb_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned MASK_W = 4;
    localparam int unsigned CNT_W  = 3;

    localparam logic M_CPU = 1'b0;
    localparam logic M_AUX = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_RDWAIT = 2'd2
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [MASK_W-1:0] wmask;
        logic              is_rd;
    } req_t;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bundle of both master ports and the shared slave bus seen by the arbiter.
interface mem_bus_arbiter_if;
    import mem_bus_arb_pkg::*;

    logic [ADDR_W-1:0] m0_addr,  m1_addr;
    logic [DATA_W-1:0] m0_wdata, m1_wdata;
    logic [MASK_W-1:0] m0_wmask, m1_wmask;
    logic              m0_rstrb, m1_rstrb;
    logic [DATA_W-1:0] m0_rdata, m1_rdata;
    logic              m0_rbusy, m1_rbusy;
    logic              m0_wbusy, m1_wbusy;

    logic [ADDR_W-1:0] s_addr;
    logic [DATA_W-1:0] s_wdata;
    logic [MASK_W-1:0] s_wmask;
    logic              s_rstrb;
    logic [DATA_W-1:0] s_rdata;

    // Arbiter side: takes master requests and slave data, drives everything else.
    modport slave (
        input  m0_addr, m1_addr, m0_wdata, m1_wdata, m0_wmask, m1_wmask,
        input  m0_rstrb, m1_rstrb, s_rdata,
        output m0_rdata, m1_rdata, m0_rbusy, m1_rbusy, m0_wbusy, m1_wbusy,
        output s_addr, s_wdata, s_wmask, s_rstrb
    );

    // Environment side: masters plus the decoded slave.
    modport master (
        output m0_addr, m1_addr, m0_wdata, m1_wdata, m0_wmask, m1_wmask,
        output m0_rstrb, m1_rstrb, s_rdata,
        input  m0_rdata, m1_rdata, m0_rbusy, m1_rbusy, m0_wbusy, m1_wbusy,
        input  s_addr, s_wdata, s_wmask, s_rstrb
    );

endinterface

// File: rtl/mem_bus_arb_port.sv
// Per-master front end: request capture, pend slot, busy flags and read-data register.
module mem_bus_arb_port
    import mem_bus_arb_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [MASK_W-1:0] wmask,
    input  logic              rstrb,
    input  logic              grant,
    input  logic              wr_done,
    input  logic              rd_done,
    input  logic [DATA_W-1:0] s_rdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rbusy,
    output logic              wbusy,
    output req_t              cand_c,
    output logic              cand_vld_c
);

    req_t pend;
    logic pend_vld;
    req_t new_c;
    logic new_req_c;

    // A write mask takes precedence over a simultaneous read strobe.
    always_comb begin
        new_c.addr  = addr;
        new_c.wdata = wdata;
        new_c.wmask = wmask;
        new_c.is_rd = (wmask == '0);
        new_req_c   = (rstrb || (wmask != '0)) && !(rbusy || wbusy);
        cand_c      = pend_vld ? pend : new_c;
        cand_vld_c  = pend_vld || new_req_c;
    end

    // Busy flags double as the outstanding marker; requests while busy are dropped.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            pend     <= '0;
            pend_vld <= 1'b0;
            rbusy    <= 1'b0;
            wbusy    <= 1'b0;
            rdata    <= '0;
        end else begin
            if (grant) begin
                pend_vld <= 1'b0;
            end else if (new_req_c) begin
                pend     <= new_c;
                pend_vld <= 1'b1;
            end
            if (new_req_c) begin
                rbusy <= new_c.is_rd;
                wbusy <= !new_c.is_rd;
            end
            if (wr_done) begin
                wbusy <= 1'b0;
            end
            if (rd_done) begin
                rbusy <= 1'b0;
                rdata <= s_rdata;
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter serialising CPU and auxiliary requests onto one strobe/mask bus.
module mem_bus_arbiter
    import mem_bus_arb_pkg::*;
#(
    parameter int unsigned RD_LAT = 1,
    parameter bit          FAIR   = 1'b1
) (
    input  logic             clk,
    input  logic             resetn,
    mem_bus_arbiter_if.slave bus
);

    state_t           state;
    logic             owner;
    logic             last_owner;
    logic             is_rd;
    logic [CNT_W-1:0] cnt;

    req_t       cand0_c, cand1_c, win_req_c;
    logic       vld0_c, vld1_c, win_c, any_c;
    logic [1:0] grant_c, wr_done_c, rd_done_c;

    mem_bus_arb_port u_port0 (
        .clk        (clk),
        .resetn     (resetn),
        .addr       (bus.m0_addr),
        .wdata      (bus.m0_wdata),
        .wmask      (bus.m0_wmask),
        .rstrb      (bus.m0_rstrb),
        .grant      (grant_c[M_CPU]),
        .wr_done    (wr_done_c[M_CPU]),
        .rd_done    (rd_done_c[M_CPU]),
        .s_rdata    (bus.s_rdata),
        .rdata      (bus.m0_rdata),
        .rbusy      (bus.m0_rbusy),
        .wbusy      (bus.m0_wbusy),
        .cand_c     (cand0_c),
        .cand_vld_c (vld0_c)
    );

    mem_bus_arb_port u_port1 (
        .clk        (clk),
        .resetn     (resetn),
        .addr       (bus.m1_addr),
        .wdata      (bus.m1_wdata),
        .wmask      (bus.m1_wmask),
        .rstrb      (bus.m1_rstrb),
        .grant      (grant_c[M_AUX]),
        .wr_done    (wr_done_c[M_AUX]),
        .rd_done    (rd_done_c[M_AUX]),
        .s_rdata    (bus.s_rdata),
        .rdata      (bus.m1_rdata),
        .rbusy      (bus.m1_rbusy),
        .wbusy      (bus.m1_wbusy),
        .cand_c     (cand1_c),
        .cand_vld_c (vld1_c)
    );

    // Winner selection and per-master grant/completion strobes.
    always_comb begin
        win_c = M_CPU;
        if (vld1_c && (!vld0_c || (FAIR && (last_owner == M_CPU)))) begin
            win_c = M_AUX;
        end
        win_req_c = (win_c == M_AUX) ? cand1_c : cand0_c;
        any_c     = vld0_c || vld1_c;
        grant_c   = '0;
        wr_done_c = '0;
        rd_done_c = '0;
        if ((state == ST_IDLE) && any_c) begin
            grant_c[win_c] = 1'b1;
        end
        if ((state == ST_ISSUE) && !is_rd) begin
            wr_done_c[owner] = 1'b1;
        end
        if ((state == ST_RDWAIT) && (cnt == CNT_W'(1))) begin
            rd_done_c[owner] = 1'b1;
        end
    end

    // Bus FSM; the s_* registers double as the issue register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= ST_IDLE;
            owner       <= M_CPU;
            last_owner  <= M_AUX;
            is_rd       <= 1'b0;
            cnt         <= '0;
            bus.s_addr  <= '0;
            bus.s_wdata <= '0;
            bus.s_wmask <= '0;
            bus.s_rstrb <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_c) begin
                        state       <= ST_ISSUE;
                        owner       <= win_c;
                        last_owner  <= win_c;
                        is_rd       <= win_req_c.is_rd;
                        bus.s_addr  <= win_req_c.addr;
                        bus.s_wdata <= win_req_c.wdata;
                        bus.s_wmask <= win_req_c.wmask;
                        bus.s_rstrb <= win_req_c.is_rd;
                    end
                end
                ST_ISSUE: begin
                    bus.s_wmask <= '0;
                    bus.s_rstrb <= 1'b0;
                    if (is_rd) begin
                        state <= ST_RDWAIT;
                        cnt   <= CNT_W'(RD_LAT);
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RDWAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
